// File: rtl/add_sub_acc_hs.sv
// add_sub_acc_hs: WIDTH-bit add/subtract stage with valid/ready handshakes, an
// internal accumulator, optional signed saturation and an accepted-op counter.
module add_sub_acc_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    input  logic             AddSub,
    input  logic             Sat,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             Overflow,
    output logic             Carryout,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] z_q, z_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH:0]   sum_s;
    logic             ovf_s;
    logic [WIDTH-1:0] res_s;

    // Single-entry output register: free when empty or being drained this cycle.
    assign in_ready = !rst && (!valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Operand selection, add/subtract and optional clamp of the accepted operation.
    always_comb begin
        x_s   = clr ? {WIDTH{1'b0}} : (Sel ? acc_q : A);
        y_s   = AddSub ? ~B : B;
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, AddSub};
        ovf_s = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);
        if (Sat && ovf_s) begin
            res_s = x_s[WIDTH-1] ? SMIN : SMAX;
        end else begin
            res_s = sum_s[WIDTH-1:0];
        end
    end

    // Next-state for result, accumulator, counter and output valid.
    always_comb begin
        z_d     = z_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        valid_d = valid_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            z_d     = res_s;
            ovf_d   = ovf_s;
            cout_d  = sum_s[WIDTH];
            valid_d = 1'b1;
            acc_d   = res_s;
            cnt_d   = clr ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end else begin
            if (out_ready) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if (clr) begin
                acc_d = {WIDTH{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end else begin
                acc_d = acc_q;
                cnt_d = cnt_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q     <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Z         = z_q;
    assign Overflow  = ovf_q;
    assign Carryout  = cout_q;
    assign out_valid = valid_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_add_sub_acc_hs.sv
// Testbench for add_sub_acc_hs: directed and random operations, scoreboard queue
// filled by the driver and drained by an independent output monitor.
module tb_add_sub_acc_hs;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  A, B;
    logic          Sel, AddSub, Sat, clr;
    logic          out_valid, out_ready;
    logic [W-1:0]  Z;
    logic          Overflow, Carryout;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [W-1:0] z;
        logic         ovf;
        logic         cout;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  m_acc;
    logic [CW-1:0] m_cnt;
    logic          m_valid;
    int            checks = 0;
    int            errors = 0;

    add_sub_acc_hs #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sel(Sel), .AddSub(AddSub), .Sat(Sat), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .Z(Z),
        .Overflow(Overflow), .Carryout(Carryout), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic.
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] b,
                                       input logic sub, input logic sat);
        exp_t r;
        int ux, ub, sx, sb, u, s;
        ux = x;
        ub = b;
        sx = $signed(x);
        sb = $signed(b);
        if (sub) begin
            u = ux - ub;
            s = sx - sb;
            r.cout = (ux >= ub);
        end else begin
            u = ux + ub;
            s = sx + sb;
            r.cout = (u > 255);
        end
        r.ovf = (s > 127) || (s < -128);
        r.z   = u[W-1:0];
        if (sat && r.ovf) r.z = (s > 127) ? 8'h7f : 8'h80;
        return r;
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic do_op(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sel, input logic asub, input logic sat,
                         input logic cl, input logic ordy);
        logic         exp_rdy, acc_now;
        logic [W-1:0] x;
        exp_t         e;
        in_valid = v; A = a; B = b; Sel = sel; AddSub = asub; Sat = sat; clr = cl;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !m_valid || ordy;
        chk("in_ready", in_ready, exp_rdy);
        acc_now = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc_now) begin
            x = cl ? 8'h00 : (sel ? m_acc : a);
            e = ref_model(x, b, asub, sat);
            exp_q.push_back(e);
            m_acc   = e.z;
            m_cnt   = cl ? 8'd1 : m_cnt + 8'd1;
            m_valid = 1'b1;
        end else begin
            if (cl) begin
                m_acc = 8'h00;
                m_cnt = 8'd0;
            end
            if (ordy) m_valid = 1'b0;
        end
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [W-1:0] z,
                             input logic ovf, input logic cout);
        chk({name, "_Z"}, Z, z);
        chk({name, "_ovf"}, Overflow, ovf);
        chk({name, "_cout"}, Carryout, cout);
        chk({name, "_valid"}, out_valid, 1'b1);
    endtask

    // Monitor: pops expected results as the DUT hands them over.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_z;
        logic         prev_ovf, prev_cout;
        exp_t         e;
        prev_stall = 1'b0;
        prev_z = 8'h00; prev_ovf = 1'b0; prev_cout = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                chk("in_ready_rst", in_ready, 1'b0);
            end else begin
                chk("out_valid", out_valid, m_valid);
                chk("op_count", op_count, m_cnt);
                if (prev_stall && out_valid) begin
                    chk("hold_Z", Z, prev_z);
                    chk("hold_ovf", Overflow, prev_ovf);
                    chk("hold_cout", Carryout, prev_cout);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_Z", Z, e.z);
                        chk("sb_ovf", Overflow, e.ovf);
                        chk("sb_cout", Carryout, e.cout);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_z = Z; prev_ovf = Overflow; prev_cout = Carryout;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; A = 8'h00; B = 8'h00; Sel = 1'b0; AddSub = 1'b0;
        Sat = 1'b0; clr = 1'b0; out_ready = 1'b1;
        m_acc = 8'h00; m_cnt = 8'd0; m_valid = 1'b0;
        #12;
        chk("rst_Z", Z, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", op_count, 8'd0);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_cout", Carryout, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // add, subtract, accumulate chain
        do_op(1'b1, 8'd25, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("add35", 8'd35, 1'b0, 1'b0);
        do_op(1'b1, 8'd40, 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_out("sub25", 8'd25, 1'b0, 1'b1);
        chk("cnt2", op_count, 8'd2);
        do_op(1'b1, 8'd0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("acc30", 8'd30, 1'b0, 1'b0);
        do_op(1'b1, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_out("acc27", 8'd27, 1'b0, 1'b1);
        chk("cnt4", op_count, 8'd4);

        // overflow, saturation, borrow
        do_op(1'b1, 8'd100, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("ovf150", 8'h96, 1'b1, 1'b0);
        do_op(1'b1, 8'd100, 8'd50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_out("sat127", 8'h7f, 1'b1, 1'b0);
        do_op(1'b1, 8'h80, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_out("satmin", 8'h80, 1'b1, 1'b1);
        do_op(1'b1, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_out("borrow", 8'hff, 1'b0, 1'b0);

        // backpressure: three stalled cycles, then drain and accept on one edge
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_Z", Z, 8'hff);
            chk("stall_cnt", op_count, 8'd8);
        end
        do_op(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("bp_add3", 8'd3, 1'b0, 1'b0);
        chk("cnt9", op_count, 8'd9);

        // clear with and without accept
        do_op(1'b1, 8'd0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_out("clr7", 8'd7, 1'b0, 1'b0);
        chk("clr_cnt1", op_count, 8'd1);
        do_op(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_holdZ", Z, 8'd7);
        chk("clr_cnt0", op_count, 8'd0);
        do_op(1'b1, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("clr_acc2", 8'd2, 1'b0, 1'b0);

        // asynchronous reset with a pending result
        do_op(1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_Z", Z, 8'h00);
        chk("arst_cnt", op_count, 8'd0);
        exp_q.delete();
        m_valid = 1'b0; m_acc = 8'h00; m_cnt = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(1'b1, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("post_rst4", 8'd4, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 9) < 7));
        end

        do_op(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_sub_acc_hs.md
Name: add_sub_acc_hs

Overview:
- Parametrised WIDTH-bit registered adder/subtractor with an internal accumulator.
- Adds valid/ready handshakes on input and output, optional signed saturation, a synchronous accumulator clear, and an operation counter.
- Successor to the fixed 8-bit add/sub unit; used as the arithmetic stage in datapaths that stream operands and need backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- A  input  WIDTH  first operand (used when Sel=0).
- B  input  WIDTH  second operand.
- Sel  input  1  0: X=A; 1: X=accumulator.
- AddSub  input  1  0: X+B; 1: X-B.
- Sat  input  1  1: clamp signed overflow to signed max/min.
- clr  input  1  synchronous clear of accumulator and counter.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Z  output  WIDTH  result.
- Overflow  output  1  signed overflow of the unclamped result.
- Carryout  output  1  carry out of MSB (subtract: 1 = no borrow).
- op_count  output  CNT_W  accepted transactions since reset/clear.

Behaviour:
- Reset (async, rst=1): Z, Overflow, Carryout, out_valid, op_count and the internal accumulator ACC all go to 0 immediately. in_ready=0 while rst=1.
- Handshake:
  - in_ready = !out_valid || out_ready (single-entry output register, combinational).
  - Accept = in_valid && in_ready at a rising edge.
- Arithmetic, on accept:
  - X = clr ? 0 : (Sel ? ACC : A).
  - Y = AddSub ? ~B : B; cin = AddSub.
  - {C, R} = X + Y + cin, computed at WIDTH+1 bits.
  - Overflow = (X[MSB] == Y[MSB]) && (R[MSB] != X[MSB]).
  - Carryout = C.
  - Z = R, unless Sat=1 and Overflow=1, in which case Z = X[MSB] ? signed-min (1000..0) : signed-max (0111..1). Overflow and Carryout still report the unclamped values.
  - ACC <= Z as clamped; op_count <= op_count+1, wrapping at 2^CNT_W to 0.
- Latency: 1 cycle. Result registers load at the accept edge; out_valid=1 from that edge on.
- Output hold: Z, Overflow and Carryout stay stable while out_valid && !out_ready.
  - out_valid falls at an edge with out_ready=1 and no new accept.
  - Accept with out_ready=1 in the same cycle: back-to-back, out_valid stays 1 and the new result replaces the old one. Full throughput is 1 per cycle.
- in_valid while stalled (out_valid && !out_ready): not accepted. Operands must be held by the source; ACC and op_count are unchanged.
- clr:
  - clr=1 without accept: ACC <= 0 and op_count <= 0 at the edge. Z and out_valid are unaffected.
  - clr=1 with accept: X forced to 0 as above. op_count <= 1 and ACC <= new Z.
- Sel=1 consecutive ops chain: each uses the ACC value from the previous accepted op.
- Reset mid-operation: pending result is discarded and out_valid=0. First accept after release of rst sees ACC=0.

Test Plan:
- Add, then subtract (WIDTH=8, out_ready=1):
  - A=25,B=10,Sel=0,AddSub=0 -> next cycle Z=35, Carryout=0, Overflow=0, out_valid=1.
  - Then A=40,B=15,AddSub=1 -> Z=25, Carryout=1, op_count=2.
- Accumulate chain: after Z=25, Sel=1,B=5,AddSub=0 -> Z=30; then Sel=1,B=3,AddSub=1 -> Z=27. ACC=27, op_count=4.
- Overflow/saturation:
  - A=100,B=50,Sat=0 -> Z=150 (0x96), Overflow=1, Carryout=0.
  - Same with Sat=1 -> Z=127, Overflow=1.
  - A=0x80,B=1,AddSub=1,Sat=1 -> Z=0x80, Overflow=1.
- Borrow: A=0,B=1,AddSub=1 -> Z=255, Carryout=0, Overflow=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and Z held. out_ready=1 -> held result consumed, next operand accepted same edge, op_count increments exactly once per accept.
- clr and reset:
  - clr=1 with Sel=1,B=7,AddSub=0 accept -> Z=7, op_count=1.
  - Assert rst while out_valid=1 -> out_valid, Z, op_count drop to 0 without a clock edge. First Sel=1,B=4 afterwards -> Z=4.
